// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    // Controller states; encodings match the original constants.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Ceiling log2, used to size the bit counter.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_sub_fs.sv
// Combinational full-subtractor cell: d = x - y - bi, with borrow-out bo.
module serial_sub_fs (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Difference bit and borrow-out of one bit position.
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~x & bi) | (y & bi);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic fs_d;
    logic fs_bo;

    serial_sub_fs u_fs (
        .x  (shift_a_q[0]),
        .y  (shift_b_q[0]),
        .bi (borrow_q),
        .d  (fs_d),
        .bo (fs_bo)
    );

    // Next-state and datapath update for the controller.
    // The final bit is folded straight into diff/bout on the edge that enters
    // DONE, so the published result is already valid while done is high.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        borrow_d  = borrow_q;
        result_d  = result_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_a_d = a;
                    shift_b_d = b;
                    borrow_d  = bin;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                result_d  = {fs_d, result_q[WIDTH-1:1]};
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                borrow_d  = fs_bo;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = {fs_d, result_q[WIDTH-1:1]};
                    bout_d  = fs_bo;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_a_q <= '0;
            shift_b_q <= '0;
            borrow_q  <= 1'b0;
            result_q  <= '0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            borrow_q  <= borrow_d;
            result_q  <= result_d;
            diff_q    <= diff_d;
            bout_q    <= bout_d;
        end
    end

    // Status and result outputs decoded from registered state.
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
        diff = diff_q;
        bout = bout_q;
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial N-bit subtractor: diff = a - b - bin, computed LSB-first, one bit per clock.
- Built around a single combinational full-subtractor cell, which is the inverse operation of the team's full adder cell.
- Used where area matters more than latency; feeds accumulator and datapath blocks through a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk    input   1      rising-edge clock.
- rst_n  input   1      asynchronous active-low reset.
- start  input   1      request; sampled only in IDLE.
- a      input   WIDTH  minuend; captured on accepted start.
- b      input   WIDTH  subtrahend; captured on accepted start.
- bin    input   1      borrow-in; captured on accepted start.
- busy   output  1      high while a subtraction is in progress.
- done   output  1      one-cycle pulse when result is valid.
- diff   output  WIDTH  result; held stable until the next accepted start.
- bout   output  1      final borrow-out; 1 means a < b + bin (unsigned).

Behaviour:
- Reset: asynchronous on rst_n low.
  - Outputs: busy=0, done=0, diff=0, bout=0.
  - Internals: state=IDLE, bit counter=0, operand shift regs=0, borrow reg=0.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: load shift_a=a, shift_b=b, borrow=bin, cnt=0; go to SHIFT; busy=1 from the next cycle.
  - start=0: remain in IDLE.
- SHIFT, every cycle:
  - Feed fs cell with x=shift_a[0], y=shift_b[0], bi=borrow.
  - fs outputs: d = x^y^bi; bo = (~x&y) | (~x&bi) | (y&bi).
  - Shift d into result reg MSB-first position (result = {d, result[WIDTH-1:1]}).
  - Shift shift_a and shift_b right by 1; borrow <= bo; cnt <= cnt+1.
  - When cnt == WIDTH-1 (last bit processed): go to DONE.
- DONE (one cycle):
  - diff <= result, bout <= borrow, done=1, busy=0; return to IDLE.
  - Result register value is exactly (a - b - bin) mod 2^WIDTH.
- Latency: start accepted in cycle T → done high in cycle T+WIDTH+1; throughput one op per WIDTH+2 cycles.
- start while busy or in DONE: ignored, no effect on the operation in progress.
- Operands a/b/bin may change after the accepted start without effect.
- diff/bout change only in DONE; they hold through the next operation until its DONE.
- start held high continuously: a new op is accepted in the first IDLE cycle after DONE.
- Reset mid-operation: immediate abort to reset values; no done pulse; partial result discarded.
- Counter width is $clog2(WIDTH)+1; no wrap is possible within an op.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Function clog2 for counter sizing.
- One sub-module, fs: combinational full subtractor.
  - Inputs x, y, bi; outputs d, bo.
  - Instantiated once in serial_sub; verified standalone with an 8-row truth table.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h23, bin=0, pulse start → done at T+9, diff=8'h37, bout=0; busy high for 8 cycles.
- a=8'h10, b=8'h20, bin=1 → diff=8'hEF, bout=1.
- a=8'h00, b=8'h00, bin=1 → diff=8'hFF, bout=1; a=8'hFF, b=8'hFF, bin=0 → diff=8'h00, bout=0.
- start=1 pulsed again at T+3 with different operands → ignored; first result 8'h37 unaffected; no extra done pulse.
- rst_n low at T+4 of an operation → busy/done/diff/bout=0 immediately; next op a=8'h80, b=8'h01, bin=0 → diff=8'h7F, bout=0.
- Random sweep of 1000 ops, WIDTH=8 and WIDTH=16, start held high back-to-back → every result matches {bout,diff} = a - b - bin as a (WIDTH+1)-bit two's-complement difference; done spacing is WIDTH+2 cycles.
